// File: rtl/predictor_sequencer.sv
// Raster-scan context sequencer for a JPEG-LS predictor: one-row line buffer, a/b/c/d neighbours, run-mode flag.
// Optional RUN_COUNT_EN adds a saturating count of run-mode pixels (run_pixels).
`ifndef PIXEL_LENGTH
`define PIXEL_LENGTH 8
`endif
`ifndef MODE_LENGTH
`define MODE_LENGTH 2
`endif

module predictor_sequencer #(
   parameter int pixel_length = `PIXEL_LENGTH,
   parameter int mode_length  = `MODE_LENGTH,
   parameter int MAX_WIDTH    = 512,
   parameter int DIM_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIM_W-1:0]        img_width,
   input  logic [DIM_W-1:0]        img_height,
   input  logic [pixel_length-1:0] in_pixel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [pixel_length-1:0] x,
   output logic [pixel_length-1:0] a,
   output logic [pixel_length-1:0] b,
   output logic [pixel_length-1:0] c,
   output logic [pixel_length-1:0] d,
   output logic [mode_length-1:0]  mode,
   output logic                    RIType,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DIM_W-1:0]        col,
   output logic [DIM_W-1:0]        row,
   output logic                    busy,
   output logic                    frame_done
`ifdef RUN_COUNT_EN
   ,
   output logic [DIM_W-1:0]        run_pixels
`endif
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

   state_t                  r_state;
   logic [DIM_W-1:0]        r_w, r_h, r_col, r_row;
   logic [pixel_length-1:0] r_a, r_c, r_c0;
   logic [pixel_length-1:0] r_x, r_ao, r_bo, r_co, r_do;
   logic [mode_length-1:0]  r_mode;
   logic                    r_ri;
   logic [pixel_length-1:0] r_linebuf [MAX_WIDTH];

   logic [AW-1:0]           w_k, w_k1;
   logic                    w_fire, w_first_row, w_first_col, w_last_col;
   logic [pixel_length-1:0] w_b, w_d, w_a, w_c;
   logic [DIM_W-1:0]        w_w_clamp;

   assign w_k         = r_col[AW-1:0];
   assign w_k1        = w_k + AW'(1);
   assign w_fire      = (r_state == FETCH) && in_valid;
   assign w_first_row = (r_row == '0);
   assign w_first_col = (r_col == '0);
   assign w_last_col  = (r_col == r_w - DIM_W'(1));
   assign w_w_clamp   = (img_width > DIM_W'(MAX_WIDTH)) ? DIM_W'(MAX_WIDTH) : img_width;

   // Neighbours come from the line buffer before this pixel overwrites its slot.
   assign w_b = w_first_row ? '0 : r_linebuf[w_k];
   assign w_d = w_first_row ? '0 : (w_last_col ? w_b : r_linebuf[w_k1]);
   assign w_a = w_first_col ? w_b  : r_a;
   assign w_c = w_first_col ? (w_first_row ? '0 : r_c0) : r_c;

   always_ff @(posedge clk) begin
      if (w_fire) r_linebuf[w_k] <= in_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_w     <= '0;
         r_h     <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_a     <= '0;
         r_c     <= '0;
         r_c0    <= '0;
         r_x     <= '0;
         r_ao    <= '0;
         r_bo    <= '0;
         r_co    <= '0;
         r_do    <= '0;
         r_mode  <= '0;
         r_ri    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_w     <= w_w_clamp;
               r_h     <= img_height;
               r_col   <= '0;
               r_row   <= '0;
               r_a     <= '0;
               r_c0    <= '0;
               r_state <= (img_width == '0 || img_height == '0) ? DONE : FETCH;
            end
            FETCH: if (in_valid) begin
               r_x    <= in_pixel;
               r_ao   <= w_a;
               r_bo   <= w_b;
               r_co   <= w_c;
               r_do   <= w_d;
               r_mode <= '0;
               r_mode[0] <= (w_d == w_b) && (w_b == w_c) && (w_c == w_a);
               r_ri   <= (w_a == w_b);
               r_a    <= in_pixel;
               r_c    <= w_b;
               if (w_first_col) r_c0 <= w_b;
               r_state <= EMIT;
            end
            EMIT: if (out_ready) begin
               if (w_last_col) begin
                  r_col <= '0;
                  if (r_row == r_h - DIM_W'(1)) r_state <= DONE;
                  else begin
                     r_row   <= r_row + DIM_W'(1);
                     r_state <= FETCH;
                  end
               end else begin
                  r_col   <= r_col + DIM_W'(1);
                  r_state <= FETCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef RUN_COUNT_EN
   logic [DIM_W-1:0] r_runs;
   always_ff @(posedge clk) begin
      if (rst) r_runs <= '0;
      else if (r_state == IDLE && start) r_runs <= '0;
      else if (r_state == EMIT && out_ready && r_mode[0] && r_runs != '1)
         r_runs <= r_runs + DIM_W'(1);
   end
   assign run_pixels = r_runs;
`endif

   assign in_ready   = (r_state == FETCH);
   assign out_valid  = (r_state == EMIT);
   assign busy       = (r_state != IDLE);
   assign frame_done = (r_state == DONE);
   assign x      = r_x;
   assign a      = r_ao;
   assign b      = r_bo;
   assign c      = r_co;
   assign d      = r_do;
   assign mode   = r_mode;
   assign RIType = r_ri;
   assign col    = r_col;
   assign row    = r_row;

endmodule
